div_unit: RTL and testbench

- Multi-cycle integer divide/remainder unit for the RV64 NPC.
- Sits directly downstream of the control unit. Accepts an operation when ALU_Control selects the divide path (code 3) and executes it with the Inside_Control sub-op.
- Radix-2 restoring divider, one quotient bit per cycle. Valid/ready handshakes on both sides.
- The core stalls on in_ready/out_valid; the result goes to the ALU result mux.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_core.sv | 60 ++++++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state type and sub-op helpers for the divide unit
package div_pkg;

  localparam logic [3:0] DIV_SEL = 4'd3;

  localparam logic [2:0] DIVW  = 3'd0;
  localparam logic [2:0] REMW  = 3'd1;
  localparam logic [2:0] DIVU  = 3'd2;
  localparam logic [2:0] DIVUW = 3'd3;
  localparam logic [2:0] REMU  = 3'd4;
  localparam logic [2:0] REMUW = 3'd5;
  localparam logic [2:0] DIV   = 3'd6;
  localparam logic [2:0] REM   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_word(input logic [2:0] op);
    return (op == DIVW) || (op == REMW) || (op == DIVUW) || (op == REMUW);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == DIVW) || (op == REMW) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == REMW) || (op == REMU) || (op == REMUW) || (op == REM);
  endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  import div_pkg::*;

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Partial remainder stays below the divisor, so the borrow bit of the
  // XLEN+1 bit trial subtraction alone decides the quotient bit.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dsr_q};
  assign remainder = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quotient  = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign done      = run_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (flush) begin
      run_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      rem_q <= '0;
      dsr_q <= divisor;
      // Word ops park the 32-bit dividend at the top so 32 shifts consume it.
      quo_q <= word ? {dividend[31:0], {(XLEN-32){1'b0}}} : dividend;
      cnt_q <= word ? CW'(31) : CW'(XLEN-1);
    end else if (run_q) begin
      rem_q <= remainder;
      quo_q <= quotient;
      if (cnt_q == '0) run_q <= 1'b0;
      else cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV64M divide/remainder unit with sign handling, special-case bypass and handshakes
module div_unit #(
  parameter int         XLEN    = 64,
  parameter logic [3:0] DIV_SEL = 4'd3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [3:0]      inside_ctrl,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import div_pkg::*;

  function automatic logic [XLEN-1:0] wfix(input logic word, input logic [XLEN-1:0] x);
    return word ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  function automatic logic [XLEN-1:0] widen(input logic word, input logic sgn, input logic [XLEN-1:0] x);
    if (!word) return x;
    return sgn ? {{(XLEN-32){x[31]}}, x[31:0]} : {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  state_t          state;
  logic            word_r, rem_r, neg_q_r, neg_r_r;
  logic [2:0]      op;
  logic            op_word, op_signed, op_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, spec_res;
  logic            a_neg, b_neg, div_zero, ovf, special, accept;
  logic            core_done;
  logic [XLEN-1:0] core_quo, core_rem, quo_fix, rem_fix, calc_res;

  assign op        = inside_ctrl[2:0];
  assign op_word   = is_word(op);
  assign op_signed = is_signed_op(op);
  assign op_rem    = is_rem(op);

  // Operands are brought to the op width first so every later test works on 64 bits.
  assign a_ext = widen(op_word, op_signed, src1);
  assign b_ext = widen(op_word, op_signed, src2);
  assign a_neg = op_signed & a_ext[XLEN-1];
  assign b_neg = op_signed & b_ext[XLEN-1];
  assign a_abs = a_neg ? ({XLEN{1'b0}} - a_ext) : a_ext;
  assign b_abs = b_neg ? ({XLEN{1'b0}} - b_ext) : b_ext;

  assign min_val  = op_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign ovf      = op_signed & (&b_ext) & (a_ext == min_val);
  assign special  = div_zero | ovf;
  assign spec_res = wfix(op_word, op_rem ? (div_zero ? a_ext : '0)
                                         : (div_zero ? '1 : a_ext));

  assign accept = in_valid & (state == IDLE) & (alu_ctrl == DIV_SEL) & ~inside_ctrl[3] & ~flush;

  div_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & ~special),
    .flush     (flush),
    .word      (op_word),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  assign quo_fix  = neg_q_r ? ({XLEN{1'b0}} - core_quo) : core_quo;
  assign rem_fix  = neg_r_r ? ({XLEN{1'b0}} - core_rem) : core_rem;
  assign calc_res = wfix(word_r, rem_r ? rem_fix : quo_fix);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      word_r  <= 1'b0;
      rem_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_r  <= op_word;
            rem_r   <= op_rem;
            neg_q_r <= (a_neg ^ b_neg) & ~div_zero;
            neg_r_r <= a_neg;
            if (special) begin
              result <= spec_res;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) state <= IDLE;
          else if (core_done) begin
            result <= calc_res;
            state  <= DONE;
          end
        end
        DONE: begin
          if (flush) begin
            result <= '0;
            state  <= IDLE;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [3:0]  inside_ctrl = 4'd0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [3:0] OP_DIVW = 4'd0, OP_REMW = 4'd1, OP_DIVU = 4'd2, OP_DIVUW = 4'd3;
  localparam logic [3:0] OP_REMU = 4'd4, OP_REMUW = 4'd5, OP_DIV = 4'd6, OP_REM = 4'd7;

  always #5 clk = ~clk;

  div_unit #(.XLEN(64), .DIV_SEL(4'd3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .inside_ctrl (inside_ctrl),
    .src1        (src1),
    .src2        (src2),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: every result handed over is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", result, 64'hx);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; presents one op for exactly one edge.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    alu_ctrl = 4'd3;
    inside_ctrl = op;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 200);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int cnt;
    exp_q.push_back(exp);
    issue(op, a, b);
    wait_valid(cnt);
    check({name, "_latency"}, 64'(cnt), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic seen;

    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    run_op("remw_m7_2", OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divw_m7_2", OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("divuw_by0", OP_DIVUW, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0", OP_REMU, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("div_m100_7", OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("rem_m100_7", OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divw_100_m7", OP_DIVW, 64'd100, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    run_op("divuw_big", OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    run_op("remuw_hi", OP_REMUW, 64'h0001_2345_FFFF_FFFF, 64'h10, 64'hF, 33);
    run_op("divu_max", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("div_by0", OP_DIV, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remw_by0", OP_REMW, 64'hDEAD_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("remuw_by0", OP_REMUW, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);

    // Backpressure, then a competing in_valid on the handshake edge.
    out_ready = 1'b0;
    exp_q.push_back(64'd10);
    issue(OP_DIVU, 64'd50, 64'd5);
    wait_valid(cnt);
    check("bp_latency", 64'(cnt), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", result, 64'd10);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'd3;
    inside_ctrl = OP_DIVU;
    src1 = 64'd9;
    src2 = 64'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_no_accept_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Flush mid-calculation.
    issue(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_never_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Flush beats a simultaneous accept in IDLE.
    in_valid = 1'b1;
    inside_ctrl = OP_DIVU;
    src1 = 64'd9;
    src2 = 64'd3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    run_op("divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

    // Asynchronous reset in the middle of a calculation.
    issue(OP_DIVU, 64'd1000, 64'd10);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_result", result, 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ops not meant for this unit are ignored.
    in_valid = 1'b1;
    alu_ctrl = 4'd0;
    inside_ctrl = OP_DIVU;
    src1 = 64'd8;
    src2 = 64'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ignore_alu_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    alu_ctrl = 4'd3;
    inside_ctrl = 4'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ignore_subop_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    run_op("divu_after_rst", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
